// File: rtl/rsa_pkg.sv
// Shared RSA definitions: state encoding, exponent width and the modmul latency,
// common to the encryption and decryption cores.
package rsa_pkg;

   localparam int RSA_WIDTH = 8;
   localparam int EXP_BITS  = 2 * RSA_WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SQR  = 2'd1;
   localparam logic [1:0] ST_MUL  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      SQR  = ST_SQR,
      MUL  = ST_MUL,
      DONE = ST_DONE
   } state_t;

   // One load cycle for the product, then one reduction step per product bit.
   function automatic int mm_latency(input int w);
      return 4 * w + 1;
   endfunction

   localparam int MM_LAT = mm_latency(RSA_WIDTH);

endpackage

// File: rtl/rsa_encrypt_ct_if.sv
// Request/response bundle between the message source and the RSA encryption core.
interface rsa_encrypt_ct_if
   import rsa_pkg::*;
#(parameter int WIDTH = RSA_WIDTH);

   logic                 start;
   logic [2*WIDTH-1:0]   m;
   logic [2*WIDTH-1:0]   e;
   logic [2*WIDTH-1:0]   n;
   logic [2*WIDTH-1:0]   c_encrypted;
   logic                 busy;
   logic                 finish;

   modport master (output start, m, e, n, input c_encrypted, busy, finish);
   modport slave  (input start, m, e, n, output c_encrypted, busy, finish);

endinterface

// File: rtl/rsa_mod_mul.sv
// Fixed-latency r = a*b mod n: full product loaded on start, then bit-serial
// restoring reduction MSB first. Latency start->finish is 4*WIDTH+1; n=0 yields 0.
module rsa_mod_mul
   import rsa_pkg::*;
#(parameter int WIDTH = RSA_WIDTH)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   a,
   input  logic [2*WIDTH-1:0]   b,
   input  logic [2*WIDTH-1:0]   n,
   output logic [2*WIDTH-1:0]   r,
   output logic                 finish
);

   localparam int OW = 2 * WIDTH;
   localparam int PW = 4 * WIDTH;
   localparam int CW = $clog2(PW);

   logic [PW-1:0] prod;
   logic [OW-1:0] rem;
   logic [CW-1:0] cnt;
   logic          run;
   logic [OW:0]   shl, rem_nx;

   // rem < n always holds, so the shifted remainder fits in OW+1 bits.
   always_comb begin
      shl    = {rem, prod[PW-1]};
      rem_nx = (shl >= {1'b0, n}) ? shl - {1'b0, n} : shl;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod   <= '0;
         rem    <= '0;
         cnt    <= '0;
         run    <= 1'b0;
         r      <= '0;
         finish <= 1'b0;
      end else begin
         finish <= 1'b0;
         if (start) begin
            prod <= PW'(a) * PW'(b);
            rem  <= '0;
            cnt  <= CW'(PW - 1);
            run  <= 1'b1;
         end else if (run) begin
            prod <= prod << 1;
            rem  <= rem_nx[OW-1:0];
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
               run    <= 1'b0;
               finish <= 1'b1;
               r      <= (n == '0) ? '0 : rem_nx[OW-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/rsa_encrypt_ct.sv
// RSA encryption c = m^e mod n, left-to-right square-and-multiply.
// RSA_CONST_TIME_EN: all exponent bits processed with an always-run multiply; otherwise leading/zero bits are skipped.
module rsa_encrypt_ct
   import rsa_pkg::*;
#(parameter int WIDTH = RSA_WIDTH)
(
   input  logic            clk,
   input  logic            rst_n,
   rsa_encrypt_ct_if.slave bus
);

   localparam int EB = 2 * WIDTH;
   localparam int IW = $clog2(EB);

   state_t         state;
   logic [EB-1:0]  m_reg, e_reg, n_reg, acc, c_q;
   logic [IW-1:0]  idx;
   logic           mm_start, mm_finish, busy_q, fin_q;
   logic [EB-1:0]  mm_b, mm_r;
   logic           sel;

   assign sel  = e_reg[idx];
   assign mm_b = (state == MUL) ? m_reg : acc;

   assign bus.c_encrypted = c_q;
   assign bus.busy        = busy_q;
   assign bus.finish      = fin_q;

   rsa_mod_mul #(.WIDTH(WIDTH)) u_mm (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mm_start),
      .a      (acc),
      .b      (mm_b),
      .n      (n_reg),
      .r      (mm_r),
      .finish (mm_finish)
   );

`ifndef RSA_CONST_TIME_EN
   logic [IW-1:0] lead_idx;

   always_comb begin
      lead_idx = '0;
      for (int k = 0; k < EB; k++)
         if (bus.e[k]) lead_idx = IW'(k);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         m_reg    <= '0;
         e_reg    <= '0;
         n_reg    <= '0;
         acc      <= '0;
         idx      <= '0;
         mm_start <= 1'b0;
         c_q      <= '0;
         busy_q   <= 1'b0;
         fin_q    <= 1'b0;
      end else begin
         mm_start <= 1'b0;
         fin_q    <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               m_reg  <= bus.m;
               e_reg  <= bus.e;
               n_reg  <= bus.n;
               acc    <= EB'(1);
               busy_q <= 1'b1;
`ifdef RSA_CONST_TIME_EN
               idx      <= IW'(EB - 1);
               state    <= SQR;
               mm_start <= 1'b1;
`else
               if (bus.e == '0) begin
                  state <= DONE;
               end else begin
                  idx      <= lead_idx;
                  state    <= SQR;
                  mm_start <= 1'b1;
               end
`endif
            end
            SQR: if (mm_finish) begin
               acc <= mm_r;
`ifdef RSA_CONST_TIME_EN
               state    <= MUL;
               mm_start <= 1'b1;
`else
               if (sel) begin
                  state    <= MUL;
                  mm_start <= 1'b1;
               end else if (idx == '0) begin
                  state <= DONE;
               end else begin
                  idx      <= idx - 1'b1;
                  mm_start <= 1'b1;
               end
`endif
            end
            MUL: if (mm_finish) begin
               // Product is always computed; the exponent bit only picks which value survives.
               acc <= sel ? mm_r : acc;
               if (idx == '0) begin
`ifdef RSA_CONST_TIME_EN
                  c_q    <= (n_reg <= EB'(1)) ? '0 : (sel ? mm_r : acc);
                  fin_q  <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
`else
                  state  <= DONE;
`endif
               end else begin
                  idx      <= idx - 1'b1;
                  state    <= SQR;
                  mm_start <= 1'b1;
               end
            end
            DONE: begin
               // n<=1 covers both the forced-zero modulus and e=0 with n=1.
               c_q    <= (n_reg <= EB'(1)) ? '0 : acc;
               fin_q  <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_encrypt_ct.sv
// Directed-vector bench for rsa_encrypt_ct; expected latency follows RSA_CONST_TIME_EN.
module tb_rsa_encrypt_ct;

   localparam int W = 8;
   localparam int L = 33;  // modmul: 1 product load + 32 reduction steps

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rsa_encrypt_ct_if #(.WIDTH(W)) bus ();
   rsa_encrypt_ct #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   function automatic int exp_lat(input logic [15:0] e);
      int ops;
      ops = 0;
`ifdef RSA_CONST_TIME_EN
      ops = 32;
      return ops * (L + 1) + 1;
`else
      for (int k = 0; k < 16; k++) if (e[k]) ops = k + 1;
      for (int k = 0; k < 16; k++) if (e[k]) ops = ops + 1;
      return ops * (L + 1) + 2;
`endif
   endfunction

   // Drives one request from a negedge, returns at the negedge where finish is seen.
   task automatic do_op(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n,
                        output logic [15:0] c, output int lat, output bit busy_ok);
      int t0, guard;
      busy_ok = 1'b1;
      bus.m = m; bus.e = e; bus.n = n; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      t0 = cyc;
      guard = 0;
      while (bus.finish !== 1'b1 && guard < 3000) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         guard++;
      end
      if (bus.busy !== 1'b0) busy_ok = 1'b0;
      lat = (guard >= 3000) ? -1 : cyc - t0 + 1;
      c = bus.c_encrypted;
   endtask

   task automatic test_reset();
      checks++; if (bus.c_encrypted !== 16'd0) begin failures++; $display("FAIL reset_c got=%0d exp=0", bus.c_encrypted); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%b exp=0", bus.finish); end
   endtask

   task automatic test_basic();
      logic [15:0] c; int lat; bit bok;
      do_op(16'd65, 16'd17, 16'd3233, c, lat, bok);
      checks++; if (c !== 16'd2790) begin failures++; $display("FAIL basic_c got=%0d exp=2790", c); end
      checks++; if (lat !== exp_lat(16'd17)) begin failures++; $display("FAIL basic_lat got=%0d exp=%0d", lat, exp_lat(16'd17)); end
      checks++; if (!bok) begin failures++; $display("FAIL basic_busy got=0 exp=1"); end
      repeat (5) @(negedge clk);
      checks++; if (bus.c_encrypted !== 16'd2790) begin failures++; $display("FAIL hold_c got=%0d exp=2790", bus.c_encrypted); end
      checks++; if (bus.finish !== 1'b0) begin failures++; $display("FAIL finish_pulse got=%b exp=0", bus.finish); end
   endtask

   task automatic test_exponents();
      logic [15:0] c; int lat; bit bok;
      logic [15:0] vm [4] = '{16'd2790, 16'd65, 16'd65, 16'd4000};
      logic [15:0] ve [4] = '{16'd413, 16'd1, 16'hFFFF, 16'd3};
      // 65^65535 mod 3233 = 609 via CRT; 4000 mod 3233 = 767, 767^3 mod 3233 = 785
      logic [15:0] vc [4] = '{16'd65, 16'd65, 16'd609, 16'd785};
      for (int k = 0; k < 4; k++) begin
         do_op(vm[k], ve[k], 16'd3233, c, lat, bok);
         checks++; if (c !== vc[k]) begin failures++; $display("FAIL exp%0d_c got=%0d exp=%0d", k, c, vc[k]); end
         checks++; if (lat !== exp_lat(ve[k])) begin failures++; $display("FAIL exp%0d_lat got=%0d exp=%0d", k, lat, exp_lat(ve[k])); end
         checks++; if (!bok) begin failures++; $display("FAIL exp%0d_busy got=0 exp=1", k); end
      end
   endtask

   task automatic test_boundaries();
      logic [15:0] c; int lat; bit bok;
      logic [15:0] vm [3] = '{16'd65, 16'd5, 16'd65};
      logic [15:0] ve [3] = '{16'd0, 16'd3, 16'd17};
      logic [15:0] vn [3] = '{16'd3233, 16'd1, 16'd0};
      logic [15:0] vc [3] = '{16'd1, 16'd0, 16'd0};
      for (int k = 0; k < 3; k++) begin
         do_op(vm[k], ve[k], vn[k], c, lat, bok);
         checks++; if (c !== vc[k]) begin failures++; $display("FAIL bnd%0d_c got=%0d exp=%0d", k, c, vc[k]); end
         checks++; if (lat !== exp_lat(ve[k])) begin failures++; $display("FAIL bnd%0d_lat got=%0d exp=%0d", k, lat, exp_lat(ve[k])); end
      end
   endtask

   // Each call starts in the finish cycle of the previous one.
   task automatic test_back_to_back();
      logic [15:0] c; int lat; bit bok;
      do_op(16'd65, 16'd17, 16'd3233, c, lat, bok);
      do_op(16'd2790, 16'd413, 16'd3233, c, lat, bok);
      checks++; if (c !== 16'd65) begin failures++; $display("FAIL b2b_c got=%0d exp=65", c); end
      checks++; if (lat !== exp_lat(16'd413)) begin failures++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, exp_lat(16'd413)); end
   endtask

   task automatic test_restart_ignored();
      int t0, guard, lat;
      bus.m = 16'd65; bus.e = 16'd17; bus.n = 16'd3233; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      t0 = cyc;
      repeat (100) @(negedge clk);
      bus.m = 16'd2790; bus.e = 16'd413; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      guard = 0;
      while (bus.finish !== 1'b1 && guard < 3000) begin @(negedge clk); guard++; end
      lat = (guard >= 3000) ? -1 : cyc - t0 + 1;
      checks++; if (bus.c_encrypted !== 16'd2790) begin failures++; $display("FAIL restart_c got=%0d exp=2790", bus.c_encrypted); end
      checks++; if (lat !== exp_lat(16'd17)) begin failures++; $display("FAIL restart_lat got=%0d exp=%0d", lat, exp_lat(16'd17)); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [15:0] c; int lat; bit bok;
      bus.m = 16'd65; bus.e = 16'd17; bus.n = 16'd3233; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (bus.c_encrypted !== 16'd0) begin failures++; $display("FAIL midrst_c got=%0d exp=0", bus.c_encrypted); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.finish !== 1'b0) begin failures++; $display("FAIL midrst_finish got=%b exp=0", bus.finish); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(16'd65, 16'd17, 16'd3233, c, lat, bok);
      checks++; if (c !== 16'd2790) begin failures++; $display("FAIL postrst_c got=%0d exp=2790", c); end
      checks++; if (lat !== exp_lat(16'd17)) begin failures++; $display("FAIL postrst_lat got=%0d exp=%0d", lat, exp_lat(16'd17)); end
   endtask

   initial begin
      bus.start = 1'b0; bus.m = '0; bus.e = '0; bus.n = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_exponents();
      test_boundaries();
      test_back_to_back();
      test_restart_ignored();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
